rom_burst_arbiter: RTL and testbench

//  Shares one 512x8 synchronous block ROM (1-cycle registered read) between N requesters.

---
 rtl/rom_arb_pkg.sv | 24 ++
 rtl/rom_burst_arbiter_rr_pick.sv | 49 ++++
 rtl/rom_burst_arbiter.sv | 175 +++++++++++++++++
 tb/tb_rom_burst_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types and constants for the ROM burst arbiter
//
// Purpose: ROM geometry, arbiter FSM state encoding and the return-path tag
//          that travels alongside each issued ROM address.
// Contents: ROM_ADDR_W, ROM_DATA_W, arb_state_t, ret_tag_t.
package rom_arb_pkg;

  localparam int ROM_ADDR_W = 9;
  localparam int ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // One tag per issued address; it reaches the output stage together with the data.
  typedef struct packed {
    logic       valid;
    logic       last;
    logic [2:0] owner;
  } ret_tag_t;

endpackage

// File: rtl/rom_burst_arbiter_rr_pick.sv
// rtl/rom_burst_arbiter_rr_pick.sv - combinational round-robin winner selection
//
// Purpose: picks the first requester above rr_ptr (wrapping to the lowest set
//          requester when nothing above rr_ptr is asking).
// Ports:
//   req      in   N_REQ  request vector
//   rr_ptr   in   3      index of the most recent winner
//   win      out  N_REQ  one-hot winner (zero when no request)
//   win_idx  out  3      binary index of the winner
//   any      out  1      at least one request present
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       rr_ptr,
  output logic [N_REQ-1:0] win,
  output logic [2:0]       win_idx,
  output logic             any
);

  logic       hi_hit;
  logic [2:0] hi_idx;
  logic [2:0] lo_idx;

  // Scanning from the top down leaves the lowest matching index in each
  // candidate: lo_* is the lowest requester overall, hi_* the lowest one
  // strictly above rr_ptr. The upper candidate wins, otherwise we wrap.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    any    = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = 3'(i);
        any    = 1'b1;
        if (3'(i) > rr_ptr) begin
          hi_idx = 3'(i);
          hi_hit = 1'b1;
        end
      end
    end
    win_idx = hi_hit ? hi_idx : lo_idx;
    win     = any ? (N_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// rtl/rom_burst_arbiter.sv - round-robin burst arbiter sharing one synchronous ROM
//
// Purpose: grants one burst at a time among N_REQ requesters, walks the ROM
//          address for L+1 bytes and returns the data tagged to its owner.
// Optional feature: define ROM_ARB_STATS_EN to add per-requester saturating
//          16-bit grant counters on output port grant_cnt.
// Ports:
//   clk        in   1             clock, posedge
//   rst_n      in   1             asynchronous active-low reset
//   req        in   N_REQ         burst request, held until its gnt pulse
//   base_addr  in   N_REQ*9       per-requester start address, [i*9 +: 9]
//   len        in   N_REQ*LEN_W   per-requester burst length minus one
//   gnt        out  N_REQ         one-cycle one-hot burst accept pulse
//   rom_addr   out  9             registered ROM address
//   rom_data   in   8             ROM data, ROM_LAT clocks after rom_addr
//   rd_data    out  8             registered copy of rom_data
//   rd_valid   out  N_REQ         one-hot owner of rd_data
//   rd_last    out  1             final byte of a burst
//   busy       out  1             burst or drain in progress
//   grant_cnt  out  N_REQ*16      (ROM_ARB_STATS_EN only) grant counters
module rom_burst_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LEN_W   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*ROM_ADDR_W-1:0] base_addr,
  input  logic [N_REQ*LEN_W-1:0]      len,
  output logic [N_REQ-1:0]            gnt,
  output logic [ROM_ADDR_W-1:0]       rom_addr,
  input  logic [ROM_DATA_W-1:0]       rom_data,
  output logic [ROM_DATA_W-1:0]       rd_data,
  output logic [N_REQ-1:0]            rd_valid,
  output logic                        rd_last,
  output logic                        busy
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]         grant_cnt
`endif
);

  arb_state_t            state;
  logic [ROM_ADDR_W-1:0] addr;
  logic [LEN_W-1:0]      cnt;
  logic [2:0]            owner;
  logic [2:0]            rr_ptr;
  logic [1:0]            dcnt;

  logic [N_REQ-1:0]      pick_win;
  logic [2:0]            pick_idx;
  logic                  pick_any;

  ret_tag_t              tag_in;
  ret_tag_t              tag_pipe [ROM_LAT+1];

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // ---------------------------------------------------------------------------
  // Arbiter FSM: IDLE picks a winner, BURST issues one address per clock,
  // DRAIN waits for the last issued byte to come back before re-arbitrating.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      addr     <= '0;
      cnt      <= '0;
      owner    <= '0;
      rr_ptr   <= 3'(N_REQ - 1);
      dcnt     <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt    <= pick_win;
            addr   <= base_addr[int'(pick_idx)*ROM_ADDR_W +: ROM_ADDR_W];
            cnt    <= len[int'(pick_idx)*LEN_W +: LEN_W];
            owner  <= pick_idx;
            rr_ptr <= pick_idx;
            busy   <= 1'b1;
            state  <= BURST;
          end
        end
        BURST: begin
          rom_addr <= addr;
          addr     <= addr + 9'd1;
          cnt      <= cnt - LEN_W'(1);
          if (cnt == '0) begin
            // DRAIN lasts dcnt+1 clocks, i.e. ROM_LAT+1.
            dcnt  <= 2'(ROM_LAT);
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dcnt == 2'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dcnt <= dcnt - 2'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Return path. The tag enters stage 0 on the same edge the address enters
  // rom_addr; ROM_LAT more stages line it up with rom_data, and the output
  // register pairs it with rd_data.
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_in       = '0;
    tag_in.valid = (state == BURST);
    tag_in.last  = (state == BURST) && (cnt == '0);
    tag_in.owner = owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
      rd_data  <= '0;
      rd_valid <= '0;
      rd_last  <= 1'b0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i <= ROM_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
      rd_data  <= rom_data;
      rd_valid <= tag_pipe[ROM_LAT].valid ? (N_REQ'(1) << tag_pipe[ROM_LAT].owner) : '0;
      rd_last  <= tag_pipe[ROM_LAT].valid && tag_pipe[ROM_LAT].last;
    end
  end

`ifdef ROM_ARB_STATS_EN
  // Saturating per-requester grant counters.
  logic [N_REQ-1:0][15:0] gcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && (gcnt_q[i] != 16'hFFFF)) begin
          gcnt_q[i] <= gcnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb/tb_rom_burst_arbiter.sv - self-checking bench for rom_burst_arbiter
module tb_rom_burst_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*9-1:0]  base_addr = '0;
  logic [N*LW-1:0] len = '0;
  logic [N-1:0]    gnt;
  logic [8:0]      rom_addr;
  logic [7:0]      rom_data = '0;
  logic [7:0]      rd_data;
  logic [N-1:0]    rd_valid;
  logic            rd_last;
  logic            busy;
`ifdef ROM_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  rom_burst_arbiter #(.N_REQ(N), .LEN_W(LW), .ROM_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .base_addr (base_addr),
    .len       (len),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .busy      (busy)
`ifdef ROM_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // 512x8 ROM, one registered read cycle, contents addr[7:0]^5A.
  always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'h5A;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: transaction-level schedule of expected outputs per cycle.
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  int         rr = N - 1;
  int         next_free = 0;
  logic [8:0] exp_addr = '0;
  logic [N-1:0] gnt_at [int];
  logic [8:0]   addr_at [int];
  logic [7:0]   dat_at [int];
  int           own_at [int];
  bit           last_at [int];

  int         gnt_log [$];
  int         gnt_cyc [$];
  logic [7:0] rd_dlog [$];
  logic [N-1:0] rd_vlog [$];
  bit         rd_llog [$];
  int         rd_cyc [$];

  task automatic model_reset();
    gnt_at.delete();
    addr_at.delete();
    dat_at.delete();
    own_at.delete();
    last_at.delete();
    rr = N - 1;
    next_free = 0;
    exp_addr = '0;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    gnt_cyc.delete();
    rd_dlog.delete();
    rd_vlog.delete();
    rd_llog.delete();
    rd_cyc.delete();
  endtask

  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] ev;
    bit           el;
    int           w;
    int           t;
    int           b;
    int           l;
    cyc++;
    if (rst_n) begin
      eg = gnt_at.exists(cyc) ? gnt_at[cyc] : '0;
      gnt_at.delete(cyc);
      chk("gnt", 32'(gnt), 32'(eg));
      if (addr_at.exists(cyc)) begin
        exp_addr = addr_at[cyc];
        addr_at.delete(cyc);
      end
      chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
      chk("busy", 32'(busy), 32'(cyc < next_free));
      ev = '0;
      el = 1'b0;
      if (dat_at.exists(cyc)) begin
        ev = N'(1) << own_at[cyc];
        el = last_at[cyc];
        chk("rd_data", 32'(rd_data), 32'(dat_at[cyc]));
        dat_at.delete(cyc);
        own_at.delete(cyc);
        last_at.delete(cyc);
      end
      chk("rd_valid", 32'(rd_valid), 32'(ev));
      chk("rd_last", 32'(rd_last), 32'(el));

      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          gnt_log.push_back(i);
          gnt_cyc.push_back(cyc);
        end
      end
      if (rd_valid != '0) begin
        rd_dlog.push_back(rd_data);
        rd_vlog.push_back(rd_valid);
        rd_llog.push_back(rd_last);
        rd_cyc.push_back(cyc);
      end

      // Arbitration decision on the request seen this cycle.
      if (cyc >= next_free && req != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req[(rr + k) % N]) w = (rr + k) % N;
        end
        b = int'(base_addr[w*9 +: 9]);
        l = int'(len[w*LW +: LW]);
        t = cyc + 1;
        gnt_at[t] = N'(1) << w;
        for (int j = 0; j <= l; j++) begin
          addr_at[t + 1 + j] = 9'((b + j) % 512);
          dat_at[t + 3 + j]  = 8'((b + j) % 256) ^ 8'h5A;
          own_at[t + 3 + j]  = w;
          last_at[t + 3 + j] = (j == l);
        end
        next_free = t + l + 3;
        rr = w;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the rising edge.
  // ---------------------------------------------------------------------------
  logic [8:0] addr_q [$];

  task automatic run_one(input int i, input logic [8:0] b, input logic [LW-1:0] l);
    bit got;
    got = 1'b0;
    addr_q.delete();
    @(posedge clk); #1;
    base_addr[i*9 +: 9] = b;
    len[i*LW +: LW] = l;
    req[i] = 1'b1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk); #1;
      if (gnt[i]) got = 1'b1;
    end
    chk("gnt_wait", 32'(got), 32'd1);
    req[i] = 1'b0;
    for (int j = 0; j <= int'(l); j++) begin
      @(posedge clk); #1;
      addr_q.push_back(rom_addr);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  cnt2;
    int  bad3;
    bit  got;
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [4];
    int  ord3 [5];

    exp1 = '{8'h4A, 8'h4B, 8'h48, 8'h49};
    exp2 = '{8'hA4, 8'hA5, 8'h5A, 8'h5B};
    ord3 = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    clear_logs();

    // All requesters at once: round-robin 0,1,2,3,0, bytes tagged per owner
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      base_addr[i*9 +: 9] = 9'(i * 64);
      len[i*LW +: LW] = 4'd1;
    end
    req = '1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #1;
      if (gnt_log.size() >= 5) got = 1'b1;
    end
    req = '0;
    chk("all_req_wait", 32'(got), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("all_req_order", 32'(gnt_log[k]), 32'(ord3[k]));
      chk("all_req_owner_a", 32'(rd_vlog[2*k]), 32'(1 << ord3[k]));
      chk("all_req_owner_b", 32'(rd_vlog[2*k+1]), 32'(1 << ord3[k]));
    end

    // Single burst req[1], base 010, len 3
    clear_logs();
    run_one(1, 9'h010, 4'd3);
    chk("t1_ngnt", 32'(gnt_log.size()), 32'd1);
    chk("t1_gnt", 32'(gnt_log[0]), 32'd1);
    chk("t1_nbytes", 32'(rd_dlog.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      chk("t1_data", 32'(rd_dlog[j]), 32'(exp1[j]));
      chk("t1_valid", 32'(rd_vlog[j]), 32'h2);
      chk("t1_last", 32'(rd_llog[j]), 32'(j == 3));
    end
    chk("t1_latency", 32'(rd_cyc[0] - gnt_cyc[0]), 32'd3);

    // Address wrap 1FE -> 001
    clear_logs();
    run_one(0, 9'h1FE, 4'd3);
    chk("t2_addr0", 32'(addr_q[0]), 32'h1FE);
    chk("t2_addr1", 32'(addr_q[1]), 32'h1FF);
    chk("t2_addr2", 32'(addr_q[2]), 32'h000);
    chk("t2_addr3", 32'(addr_q[3]), 32'h001);
    for (int j = 0; j < 4; j++) chk("t2_data", 32'(rd_dlog[j]), 32'(exp2[j]));

    // req[2] drops one cycle after gnt; req[3] pulses while busy
    clear_logs();
    @(posedge clk); #1;
    base_addr[2*9 +: 9] = 9'h123;
    len[2*LW +: LW] = 4'd5;
    req[2] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk); #1;
      if (gnt[2]) got = 1'b1;
    end
    chk("t4_gnt_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    base_addr[3*9 +: 9] = 9'h0AA;
    req[3] = 1'b1;
    @(posedge clk); #1;
    req[3] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    cnt2 = 0;
    bad3 = 0;
    foreach (rd_vlog[k]) begin
      if (rd_vlog[k] == 4'b0100) cnt2++;
      if (rd_vlog[k][3]) bad3++;
    end
    chk("t4_bytes_req2", 32'(cnt2), 32'd6);
    chk("t4_no_req3_data", 32'(bad3), 32'd0);
    chk("t4_ngnt", 32'(gnt_log.size()), 32'd1);

    // Asynchronous reset in the middle of a 16-byte burst
    @(posedge clk); #1;
    base_addr[0 +: 9] = 9'h050;
    len[0 +: LW] = 4'd15;
    req[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk); #1;
      if (gnt[0]) got = 1'b1;
    end
    chk("t5_gnt_wait", 32'(got), 32'd1);
    req[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_async");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    repeat (30) @(posedge clk);
    #1;
    chk("t5_no_rd_after_reset", 32'(rd_vlog.size()), 32'd0);
    chk("t5_no_gnt_after_reset", 32'(gnt_log.size()), 32'd0);

`ifdef ROM_ARB_STATS_EN
    // Grant counters: count, then saturate
    for (int k = 0; k < 5; k++) run_one(0, 9'h020, 4'd0);
    chk("t6_cnt5", 32'(grant_cnt[15:0]), 32'd5);
    @(posedge clk); #1;
    force dut.gcnt_q[0] = 16'hFFFE;
    @(posedge clk); #1;
    release dut.gcnt_q[0];
    for (int k = 0; k < 3; k++) run_one(0, 9'h020, 4'd0);
    chk("t6_sat", 32'(grant_cnt[15:0]), 32'hFFFF);
`endif

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (gnt[i]) req[i] = 1'b0;
          else if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          base_addr[i*9 +: 9] = 9'($urandom);
          len[i*LW +: LW] = LW'($urandom);
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    repeat (40) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
